// File: rtl/led_flow_pkg.sv
// Shared encodings for the led_flow_n animation block.
// Mode select values and bounce direction type.
package led_flow_pkg;

   localparam logic [1:0] MODE_ROT   = 2'b00;
   localparam logic [1:0] MODE_BNC   = 2'b01;
   localparam logic [1:0] MODE_FILL  = 2'b10;
   localparam logic [1:0] MODE_BLINK = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/led_flow_n_prescaler.sv
// Programmable step prescaler: one tick every max(period,1) enabled cycles.
// A clear (mode change) restarts the count and suppresses the tick.
module led_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             enable,
   input  logic             clr,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last;

   // >= so a period shrunk below the running count fires on the next cycle
   assign last = (period == '0) ? '0 : period - DIV_W'(1);
   assign tick = enable && !clr && (cnt >= last);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_flow_n.sv
// N-wide LED animator: rotate, bounce, fill/drain and blink modes
// stepped by an internal run-time programmable prescaler.
module led_flow_n
   import led_flow_pkg::*;
#(
   parameter int N_LED = 16,
   parameter int DIV_W = 24
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             SW_in,
   input  logic [1:0]       mode,
   input  logic             enable,
   input  logic [DIV_W-1:0] period,
   output logic [N_LED-1:0] led,
   output logic             step
);

   localparam int FW = $clog2(N_LED + 1);
   localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);

   logic [1:0]       mode_q;
   logic [N_LED-1:0] led_q, led_d;
   logic [FW-1:0]    fill_q, fill_d;
   dir_t             dir_q, dir_d;
   logic             step_q;
   logic             mode_chg;
   logic             tick;
   logic             onehot;

   function automatic logic [N_LED-1:0] fill_map(
      input logic [FW-1:0] k,
      input logic          hi
   );
      logic [N_LED-1:0] m;
      m = '0;
      for (int i = 0; i < N_LED; i++) begin
         if (hi) m[i] = (i >= N_LED - int'(k));
         else    m[i] = (i < int'(k));
      end
      return m;
   endfunction

   assign mode_chg = (mode != mode_q);
   assign onehot   = (led_q != '0) &&
                     ((led_q & (led_q - LED_ONE)) == '0);

   led_prescaler #(
      .DIV_W (DIV_W)
   ) u_presc (
      .CLK    (CLK),
      .reset  (reset),
      .enable (enable),
      .clr    (mode_chg),
      .period (period),
      .tick   (tick)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         mode_q <= MODE_ROT;
         led_q  <= LED_ONE;
         fill_q <= '0;
         dir_q  <= DIR_UP;
         step_q <= 1'b0;
      end else begin
         mode_q <= mode;
         led_q  <= led_d;
         fill_q <= fill_d;
         dir_q  <= dir_d;
         step_q <= tick;
      end
   end

   always_comb begin
      led_d  = led_q;
      fill_d = fill_q;
      dir_d  = dir_q;
      if (mode_chg) begin
         unique case (mode)
            MODE_ROT:   led_d = LED_ONE;
            MODE_BNC: begin
               led_d = LED_ONE;
               dir_d = DIR_UP;
            end
            MODE_FILL: begin
               fill_d = '0;
               led_d  = '0;
            end
            MODE_BLINK: led_d = '0;
            default:    led_d = LED_ONE;
         endcase
      end else if (tick) begin
         unique case (mode_q)
            MODE_ROT: begin
               if (!onehot)    led_d = LED_ONE;
               else if (SW_in) led_d = {led_q[0], led_q[N_LED-1:1]};
               else            led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
            end
            MODE_BNC: begin
               // end LEDs turn around on their own step, lit once each
               if (!onehot) begin
                  led_d = LED_ONE;
               end else if (dir_q == DIR_UP) begin
                  if (led_q[N_LED-1]) begin
                     dir_d = DIR_DOWN;
                     led_d = led_q >> 1;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     dir_d = DIR_UP;
                     led_d = led_q << 1;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            MODE_FILL: begin
               fill_d = (fill_q == FW'(N_LED)) ? '0 : fill_q + FW'(1);
               led_d  = fill_map(fill_d, SW_in);
            end
            MODE_BLINK: led_d = ~led_q;
            default:    led_d = LED_ONE;
         endcase
      end else if (enable && mode_q == MODE_FILL) begin
         led_d = fill_map(fill_q, SW_in);
      end
   end

   assign led  = led_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_flow_n.sv
// Directed bench for led_flow_n at N_LED=8, period=4.
module tb_led_flow_n;

   logic        clk;
   logic        reset;
   logic        sw;
   logic [1:0]  mode;
   logic        enable;
   logic [23:0] period;
   logic [7:0]  led;
   logic        step;

   int n_cmp = 0;
   int n_err = 0;

   led_flow_n #(
      .N_LED (8),
      .DIV_W (24)
   ) dut (
      .CLK    (clk),
      .reset  (reset),
      .SW_in  (sw),
      .mode   (mode),
      .enable (enable),
      .period (period),
      .led    (led),
      .step   (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!step && n < 40);
   endtask

   task automatic test_reset();
      int n;
      logic [7:0] seq [8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h01};
      reset = 1'b0; sw = 1'b0; mode = 2'b00;
      enable = 1'b1; period = 24'd4;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if (led !== 8'h01 || step !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: led=%h step=%b want 01/0", led, step);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_step(n);
         n_cmp++;
         if (n !== 4 || led !== seq[i]) begin
            n_err++;
            $display("FAIL rot_left[%0d]: gap=%0d led=%h want 4/%h",
                     i, n, led, seq[i]);
         end
      end
   endtask

   task automatic test_rotate_right();
      int n;
      logic [7:0] fast [4] = '{8'h20, 8'h10, 8'h08, 8'h04};
      sw = 1'b1;
      wait_step(n);
      n_cmp++;
      if (n !== 4 || led !== 8'h80) begin
         n_err++;
         $display("FAIL rot_right0: gap=%0d led=%h want 4/80", n, led);
      end
      wait_step(n);
      n_cmp++;
      if (n !== 4 || led !== 8'h40) begin
         n_err++;
         $display("FAIL rot_right1: gap=%0d led=%h want 4/40", n, led);
      end
      period = 24'd0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_cmp++;
         if (step !== 1'b1 || led !== fast[i]) begin
            n_err++;
            $display("FAIL period0[%0d]: step=%b led=%h want 1/%h",
                     i, step, led, fast[i]);
         end
      end
      period = 24'd4;
   endtask

   task automatic test_bounce();
      int n;
      logic [7:0] seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                               8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                               8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      sw = 1'b0; mode = 2'b01;
      cyc();
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_err++;
         $display("FAIL bnc_entry: led=%h step=%b want 01/0", led, step);
      end
      for (int i = 0; i < 15; i++) begin
         wait_step(n);
         n_cmp++;
         if (n !== 4 || led !== seq[i]) begin
            n_err++;
            $display("FAIL bounce[%0d]: gap=%0d led=%h want 4/%h",
                     i, n, led, seq[i]);
         end
      end
   endtask

   task automatic test_mode_switch();
      int n;
      for (int i = 0; i < 8; i++) wait_step(n);
      n_cmp++;
      if (led !== 8'h20) begin
         n_err++;
         $display("FAIL bnc_down20: led=%h want 20", led);
      end
      mode = 2'b00;
      cyc();
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_err++;
         $display("FAIL sw_rot_entry: led=%h step=%b want 01/0", led, step);
      end
      wait_step(n);
      n_cmp++;
      if (n !== 4 || led !== 8'h02) begin
         n_err++;
         $display("FAIL sw_rot_first: gap=%0d led=%h want 4/02", n, led);
      end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (led !== 8'h01 || step !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: led=%h step=%b want 01/0", led, step);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_fill();
      int n;
      logic [7:0] seq [12] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F,
                               8'h7F, 8'hFF, 8'h00, 8'h01, 8'h03, 8'h07};
      sw = 1'b0; mode = 2'b10;
      cyc();
      n_cmp++;
      if (led !== 8'h00) begin
         n_err++;
         $display("FAIL fill_entry: led=%h want 00", led);
      end
      for (int i = 0; i < 12; i++) begin
         wait_step(n);
         n_cmp++;
         if (n !== 4 || led !== seq[i]) begin
            n_err++;
            $display("FAIL fill[%0d]: gap=%0d led=%h want 4/%h",
                     i, n, led, seq[i]);
         end
      end
      sw = 1'b1;
      cyc();
      n_cmp++;
      if (led !== 8'hE0 || step !== 1'b0) begin
         n_err++;
         $display("FAIL fill_remap: led=%h step=%b want E0/0", led, step);
      end
      wait_step(n);
      n_cmp++;
      if (n !== 3 || led !== 8'hF0) begin
         n_err++;
         $display("FAIL fill_hi4: gap=%0d led=%h want 3/F0", n, led);
      end
   endtask

   task automatic test_blink_freeze();
      int n;
      int bad;
      mode = 2'b11;
      cyc();
      n_cmp++;
      if (led !== 8'h00) begin
         n_err++;
         $display("FAIL blink_entry: led=%h want 00", led);
      end
      wait_step(n);
      n_cmp++;
      if (n !== 4 || led !== 8'hFF) begin
         n_err++;
         $display("FAIL blink1: gap=%0d led=%h want 4/FF", n, led);
      end
      wait_step(n);
      n_cmp++;
      if (n !== 4 || led !== 8'h00) begin
         n_err++;
         $display("FAIL blink2: gap=%0d led=%h want 4/00", n, led);
      end
      cyc();
      cyc();
      enable = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (led !== 8'h00 || step !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL freeze: bad_cycles=%0d want 0", bad);
      end
      enable = 1'b1;
      wait_step(n);
      n_cmp++;
      if (n !== 2 || led !== 8'hFF) begin
         n_err++;
         $display("FAIL resume: gap=%0d led=%h want 2/FF", n, led);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rotate_right();
      test_bounce();
      test_mode_switch();
      test_fill();
      test_blink_freeze();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
